// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Frame layout: two length bytes, 4*N payload bytes, one XOR checksum byte.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  // States in which the loader still consumes stream bytes.
  function automatic logic is_rx_state(input state_t s);
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs stream bytes MSB-first into 32-bit words; word_done marks the strobe
// carrying the final byte, with packed_word valid in that same cycle.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_byte,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] packed_word,
  output logic        word_done
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam int SW = 8 * (BYTES_PER_WORD - 1);

  logic [CW-1:0] cnt_r;
  logic [SW-1:0] shift_r;

  assign packed_word = {shift_r, data_byte};
  assign word_done   = strobe && (cnt_r == CW'(BYTES_PER_WORD - 1));

  // Byte counter and shift register of the bytes preceding the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      shift_r <= '0;
    end else if (clear) begin
      cnt_r   <= '0;
      shift_r <= '0;
    end else if (strobe) begin
      cnt_r   <= cnt_r + CW'(1);
      shift_r <= {shift_r[SW-9:0], data_byte};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum frame, writes words to
// instruction memory from address 0 and releases the CPU only on success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   word_cnt
);

  localparam int LEN_W = 8 * LEN_BYTES;
  localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(2 ** ADDR_WIDTH);

  state_t                state_r;
  state_t                state_s;
  logic [LEN_W-1:0]      len_r;
  logic [7:0]            xor_r;
  logic [ADDR_WIDTH:0]   word_cnt_r;
  logic [ADDR_WIDTH:0]   cnt_next_s;
  logic                  im_we_r;
  logic [ADDR_WIDTH-1:0] im_addr_r;
  logic [31:0]           im_wdata_r;
  logic                  cpu_rst_r;
  logic                  load_done_r;
  logic                  load_err_r;

  logic                  rx_ready_s;
  logic                  accept_s;
  logic [LEN_W-1:0]      len_full_s;
  logic                  len_too_big_s;
  logic                  len_zero_s;
  logic                  last_word_s;
  logic                  pack_strobe_s;
  logic                  pack_clear_s;
  logic [31:0]           packed_word_s;
  logic                  word_done_s;

  // Ready drops during reset even though the state already reads S_LEN_HI.
  assign rx_ready_s    = is_rx_state(state_r) && !rst;
  assign accept_s      = rx_valid && rx_ready_s;
  assign len_full_s    = {len_r[LEN_W-1:8], rx_data};
  assign len_too_big_s = {1'b0, len_full_s} > CAPACITY;
  assign len_zero_s    = (len_full_s == {LEN_W{1'b0}});
  assign cnt_next_s    = word_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_word_s   = ({1'b0, len_r} == (LEN_W + 1)'(cnt_next_s));
  assign pack_strobe_s = accept_s && (state_r == S_DATA);
  assign pack_clear_s  = (state_r != S_DATA);

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .data_byte   (rx_data),
    .strobe      (pack_strobe_s),
    .clear       (pack_clear_s),
    .packed_word (packed_word_s),
    .word_done   (word_done_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_LEN_HI;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame sequencing; DONE and ERR are terminal until reset.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_LEN_HI: begin
        if (accept_s) state_s = S_LEN_LO;
        else          state_s = state_r;
      end
      S_LEN_LO: begin
        if (!accept_s)         state_s = state_r;
        else if (len_too_big_s) state_s = S_ERR;
        else if (len_zero_s)    state_s = S_CSUM;
        else                    state_s = S_DATA;
      end
      S_DATA: begin
        if (word_done_s && last_word_s) state_s = S_CSUM;
        else                            state_s = state_r;
      end
      S_CSUM: begin
        if (!accept_s)              state_s = state_r;
        else if (rx_data == xor_r)  state_s = S_DONE;
        else                        state_s = S_ERR;
      end
      S_DONE:  state_s = S_DONE;
      S_ERR:   state_s = S_ERR;
      default: state_s = S_ERR;
    endcase
  end

  // Length capture, checksum accumulation, write issue and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r       <= '0;
      xor_r       <= 8'h00;
      word_cnt_r  <= '0;
      im_we_r     <= 1'b0;
      im_addr_r   <= '0;
      im_wdata_r  <= 32'h0000_0000;
      cpu_rst_r   <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      im_we_r <= word_done_s;
      if (word_done_s) begin
        im_addr_r  <= word_cnt_r[ADDR_WIDTH-1:0];
        im_wdata_r <= packed_word_s;
        word_cnt_r <= cnt_next_s;
      end
      if (accept_s && (state_r == S_LEN_HI)) len_r[LEN_W-1:8] <= rx_data;
      if (accept_s && (state_r == S_LEN_LO)) len_r <= len_full_s;
      // The checksum byte itself is compared, never folded in.
      if (accept_s && (state_r != S_CSUM)) xor_r <= csum_step(xor_r, rx_data);
      cpu_rst_r   <= (state_s != S_DONE);
      load_done_r <= (state_s == S_DONE);
      load_err_r  <= (state_s == S_ERR);
    end
  end

  assign rx_ready  = rx_ready_s;
  assign im_we     = im_we_r;
  assign im_addr   = im_addr_r;
  assign im_wdata  = im_wdata_r;
  assign cpu_rst   = cpu_rst_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;
  assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-position model checked every cycle, plus
// literal expectations on captured memory contents and final status.
module tb_imem_loader;

  localparam int AW  = 4;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_cnt;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position inside the frame decides what each accepted byte means.
  // m_st: 0 = still receiving, 1 = loaded, 2 = error.
  int          m_pos = 0;
  int          m_n = 0;
  int          m_st = 0;
  int          m_addr = 0;
  int          m_cnt = 0;
  logic [7:0]  m_hi = 8'h00;
  logic [7:0]  m_x = 8'h00;
  logic [31:0] m_w = 32'h0;
  logic [31:0] m_data = 32'h0;
  logic        m_we = 1'b0;

  logic [31:0] mem [CAP];
  int          n_wr = 0;
  int          last_addr = -1;
  logic [7:0]  frame [$];
  logic [31:0] wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    logic [7:0] b;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_pos = 0; m_n = 0; m_st = 0; m_addr = 0; m_cnt = 0;
      m_hi = 8'h00; m_x = 8'h00; m_w = 32'h0; m_data = 32'h0; m_we = 1'b0;
    end else begin
      m_we = 1'b0;
      if (rx_valid && m_st == 0) begin
        b = rx_data;
        if (m_pos == 0) begin
          m_hi = b; m_x = m_x ^ b;
        end else if (m_pos == 1) begin
          m_n = int'({m_hi, b}); m_x = m_x ^ b;
          if (m_n > CAP) m_st = 2;
        end else if (m_pos < 2 + 4 * m_n) begin
          m_x = m_x ^ b;
          m_w = {m_w[23:0], b};
          if ((m_pos - 2) % 4 == 3) begin
            m_we = 1'b1; m_addr = (m_pos - 2) / 4; m_data = m_w; m_cnt++;
          end
        end else begin
          m_st = (b == m_x) ? 1 : 2;
        end
        m_pos++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (im_we === 1'b1) begin
      mem[im_addr] = im_wdata;
      n_wr++;
      last_addr = int'(im_addr);
    end
    chk("rx_ready", rx_ready, !rst && m_st == 0);
    chk("im_we", im_we, m_we);
    chk("im_addr", im_addr, m_addr[AW-1:0]);
    chk("im_wdata", im_wdata, m_data);
    chk("word_cnt", word_cnt, m_cnt);
    chk("cpu_rst", cpu_rst, m_st != 1);
    chk("load_done", load_done, m_st == 1);
    chk("load_err", load_err, m_st == 2);
  end

  task automatic apply_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < CAP; i++) mem[i] = 32'h0;
    n_wr = 0;
    last_addr = -1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic make_frame(input bit bad_csum);
    logic [7:0] x;
    logic [15:0] n;
    n = 16'(wq.size());
    frame.delete();
    frame.push_back(n[15:8]);
    frame.push_back(n[7:0]);
    foreach (wq[i]) for (int k = 3; k >= 0; k--) frame.push_back(wq[i][8*k +: 8]);
    x = 8'h00;
    foreach (frame[i]) x = x ^ frame[i];
    frame.push_back(bad_csum ? (x ^ 8'h01) : x);
  endtask

  task automatic send(input int first, input int count, input int gap_max);
    for (int i = first; i < first + count; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          rx_valid = 1'b0;
          @(negedge clk);
        end
      end
      rx_valid = 1'b1;
      rx_data  = frame[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    apply_reset();
    chk("reset cpu_rst", cpu_rst, 1'b1);
    chk("reset word_cnt", word_cnt, 32'd0);

    // N=2, correct checksum (0x57 by hand).
    wq = '{32'h2008_0005, 32'h0109_5020};
    make_frame(1'b0);
    send(0, frame.size(), 0);
    repeat (3) @(negedge clk);
    chk("A csum byte", frame[10], 32'h57);
    chk("A mem0", mem[0], 32'h2008_0005);
    chk("A mem1", mem[1], 32'h0109_5020);
    chk("A writes", n_wr, 32'd2);
    chk("A done", load_done, 1'b1);
    chk("A cpu_rst", cpu_rst, 1'b0);
    chk("A word_cnt", word_cnt, 32'd2);

    // Same frame, checksum flipped.
    apply_reset();
    make_frame(1'b1);
    send(0, frame.size(), 0);
    repeat (3) @(negedge clk);
    chk("B writes", n_wr, 32'd2);
    chk("B err", load_err, 1'b1);
    chk("B cpu_rst", cpu_rst, 1'b1);
    chk("B ready", rx_ready, 1'b0);

    // Empty image.
    apply_reset();
    wq.delete();
    make_frame(1'b0);
    send(0, frame.size(), 0);
    chk("N0 done", load_done, 1'b1);
    chk("N0 writes", n_wr, 32'd0);

    // One word over capacity: error right after LEN_LO, nothing written.
    apply_reset();
    frame = '{8'h00, 8'h11};
    send(0, 2, 0);
    chk("N17 err", load_err, 1'b1);
    repeat (3) @(negedge clk);
    chk("N17 writes", n_wr, 32'd0);

    // Exactly full memory.
    apply_reset();
    wq.delete();
    for (int i = 0; i < CAP; i++) wq.push_back(32'h1000_0000 + 32'(i) * 32'h0101_0101);
    make_frame(1'b0);
    send(0, frame.size(), 0);
    repeat (2) @(negedge clk);
    chk("N16 writes", n_wr, 32'd16);
    chk("N16 last addr", last_addr, 32'd15);
    chk("N16 mem15", mem[15], 32'h1F0F_0F0F);
    chk("N16 word_cnt", word_cnt, 32'd16);
    chk("N16 done", load_done, 1'b1);

    // Frame A with random valid gaps.
    apply_reset();
    wq = '{32'h2008_0005, 32'h0109_5020};
    make_frame(1'b0);
    send(0, frame.size(), 3);
    repeat (2) @(negedge clk);
    chk("gap mem0", mem[0], 32'h2008_0005);
    chk("gap mem1", mem[1], 32'h0109_5020);
    chk("gap done", load_done, 1'b1);

    // Reset after LEN + 6 payload bytes, then a fresh 3-word frame.
    apply_reset();
    send(0, 8, 0);
    apply_reset();
    wq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    make_frame(1'b0);
    send(0, frame.size(), 1);
    repeat (2) @(negedge clk);
    chk("rst mem0", mem[0], 32'h1111_1111);
    chk("rst mem2", mem[2], 32'h3333_3333);
    chk("rst writes", n_wr, 32'd3);
    chk("rst word_cnt", word_cnt, 32'd3);
    chk("rst done", load_done, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
